// File: rtl/vgpr_wb_arbiter_pkg.sv
// Shared constants and types for the VGPR write-back port arbiter.
// The arbiter chooses between eight ALU queues and the LSU.
package vgpr_wb_arbiter_pkg;

   localparam int         NUM_ALU      = 8;
   localparam logic [3:0] FU_LSU       = 4'd8;
   localparam logic [3:0] FU_NONE      = 4'd15;
   localparam logic [3:0] STARVE_LIMIT = 4'd8;
   localparam logic [3:0] STARVE_MAX   = 4'd15;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_ALU,
      GRANT_LSU
   } grant_kind_e;

   function automatic logic [2:0] onehot_to_idx(input logic [NUM_ALU-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_ALU; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_find_first8.sv
// Rotating find-first: grants the first set request bit at or after ptr,
// wrapping from bit 7 back to bit 0.
module rr_find_first8
   import vgpr_wb_arbiter_pkg::*;
(
   input  logic [NUM_ALU-1:0] req,
   input  logic [2:0]         ptr,
   output logic [NUM_ALU-1:0] grant,
   output logic               valid
);

   // NOTE: every output gets a default at the top of always_comb, otherwise
   // the paths that never assign it infer a latch.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_ALU; i++) begin
         // The 3-bit sum wraps modulo 8, which gives the 7->0 rotation.
         if (!valid && req[ptr + 3'(i)]) begin
            grant[ptr + 3'(i)] = 1'b1;
            valid              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vgpr_wb_arbiter.sv
// VGPR write-back port arbiter: the LSU has priority, the ALUs share the port
// round-robin, and a starvation counter periodically holds the LSU off.
module vgpr_wb_arbiter
   import vgpr_wb_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_ALU-1:0] alu_queue_entry_valid,
   input  logic               lsu_dest_wr_req,
   output logic [NUM_ALU-1:0] alu_queue_entry_serviced,
   output logic               lsu_wr_grant,
   output logic [3:0]         wr_fu_select,
   output logic               lsu_stall
);

   logic [2:0]         rr_ptr;
   logic [3:0]         starve_cnt;
   logic [NUM_ALU-1:0] eligible;
   logic [NUM_ALU-1:0] rr_grant;
   logic               rr_valid;
   logic               relief;
   logic [2:0]         win_idx;
   grant_kind_e        kind;

   // After a serviced pulse, a queue still shows valid for one more cycle.
   // The registered serviced vector therefore also acts as the exclusion mask.
   assign eligible = alu_queue_entry_valid & ~alu_queue_entry_serviced;
   assign relief   = (starve_cnt >= STARVE_LIMIT);
   assign win_idx  = onehot_to_idx(rr_grant);

   rr_find_first8 u_find (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .valid (rr_valid)
   );

   always_comb begin
      kind = GRANT_NONE;
      if (lsu_dest_wr_req && !(relief && rr_valid)) begin
         kind = GRANT_LSU;
      end else if (rr_valid) begin
         kind = GRANT_ALU;
      end
   end

   // NOTE: all state here uses non-blocking assignments, so every register
   // sees the values from before the clock edge, whatever order they are written in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_queue_entry_serviced <= '0;
         lsu_wr_grant             <= 1'b0;
         wr_fu_select             <= FU_NONE;
         lsu_stall                <= 1'b0;
         rr_ptr                   <= '0;
         starve_cnt               <= '0;
      end else begin
         case (kind)
            GRANT_LSU: begin
               alu_queue_entry_serviced <= '0;
               lsu_wr_grant             <= 1'b1;
               wr_fu_select             <= FU_LSU;
               lsu_stall                <= 1'b0;
               if (!rr_valid) begin
                  starve_cnt <= '0;
               end else if (starve_cnt != STARVE_MAX) begin
                  starve_cnt <= starve_cnt + 4'd1;
               end
            end
            GRANT_ALU: begin
               alu_queue_entry_serviced <= rr_grant;
               lsu_wr_grant             <= 1'b0;
               wr_fu_select             <= {1'b0, win_idx};
               // On this path a pending LSU request means relief is active.
               lsu_stall                <= lsu_dest_wr_req;
               rr_ptr                   <= win_idx + 3'd1;
               starve_cnt               <= '0;
            end
            default: begin
               alu_queue_entry_serviced <= '0;
               lsu_wr_grant             <= 1'b0;
               wr_fu_select             <= FU_NONE;
               lsu_stall                <= 1'b0;
               starve_cnt               <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vgpr_wb_arbiter.sv
// Self-checking bench for vgpr_wb_arbiter. A behavioural model pushes the
// expected registered outputs, and they are compared one cycle later.
module tb_vgpr_wb_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] valid;
   logic       lsu_req;
   logic [7:0] serviced;
   logic       lsu_grant;
   logic [3:0] sel;
   logic       stall;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] serviced;
      logic       lsu_grant;
      logic [3:0] sel;
      logic       stall;
   } obs_t;

   obs_t       exp_q[$];
   logic [2:0] m_ptr;
   logic [3:0] m_cnt;
   logic [7:0] m_excl;

   always #5 clk = ~clk;

   vgpr_wb_arbiter dut (
      .clk                      (clk),
      .rst                      (rst),
      .alu_queue_entry_valid    (valid),
      .lsu_dest_wr_req          (lsu_req),
      .alu_queue_entry_serviced (serviced),
      .lsu_wr_grant             (lsu_grant),
      .wr_fu_select             (sel),
      .lsu_stall                (stall)
   );

   function automatic obs_t observe();
      return '{serviced, lsu_grant, sel, stall};
   endfunction

   task automatic model_reset();
      m_ptr  = '0;
      m_cnt  = '0;
      m_excl = '0;
      exp_q.delete();
   endtask

   task automatic predict(input logic [7:0] v, input logic l);
      logic [7:0] elig;
      bit         found;
      int         win;
      obs_t       e;
      elig  = v & ~m_excl;
      found = 0;
      win   = 0;
      for (int k = 0; k < 8; k++) begin
         if (!found && elig[(int'(m_ptr) + k) % 8]) begin
            found = 1;
            win   = (int'(m_ptr) + k) % 8;
         end
      end
      if (l && !(m_cnt >= 4'd8 && found)) begin
         e      = '{8'h00, 1'b1, 4'd8, 1'b0};
         m_cnt  = !found ? 4'd0 : (m_cnt == 4'd15 ? 4'd15 : 4'(m_cnt + 4'd1));
         m_excl = '0;
      end else if (found) begin
         e      = '{8'(1 << win), 1'b0, 4'(win), l};
         m_ptr  = 3'((win + 1) % 8);
         m_cnt  = '0;
         m_excl = 8'(1 << win);
      end else begin
         e      = '{8'h00, 1'b0, 4'd15, 1'b0};
         m_cnt  = '0;
         m_excl = '0;
      end
      exp_q.push_back(e);
   endtask

   // Called at a falling edge. Drives the inputs, then scores the outputs
   // registered at the next rising edge, and returns at the following falling edge.
   task automatic step(input logic [7:0] v, input logic l, input string name,
                       output obs_t got);
      obs_t e;
      valid   = v;
      lsu_req = l;
      predict(v, l);
      @(posedge clk);
      #1;
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: got serviced=%h lsu_grant=%b sel=%0d stall=%b, expected serviced=%h lsu_grant=%b sel=%0d stall=%b",
                  name, got.serviced, got.lsu_grant, got.sel, got.stall,
                  e.serviced, e.lsu_grant, e.sel, e.stall);
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst     = 1'b1;
      valid   = '0;
      lsu_req = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      valid   = '0;
      lsu_req = 1'b0;
      model_reset();
      #1;
      checks++;
      if (observe() !== obs_t'({8'h00, 1'b0, 4'd15, 1'b0})) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected serviced=00 grant=0 sel=15 stall=0", observe());
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      obs_t g;
      apply_reset();
      step(8'h01, 1'b0, "single_first", g);
      checks++;
      if (g.serviced !== 8'h01 || g.sel !== 4'd0) begin
         errors++;
         $display("FAIL single_first: got serviced=%h sel=%0d, expected 01 and 0", g.serviced, g.sel);
      end
      step(8'h01, 1'b0, "single_excluded", g);
      checks++;
      if (g.serviced !== 8'h00 || g.sel !== 4'd15) begin
         errors++;
         $display("FAIL single_excluded: got serviced=%h sel=%0d, expected 00 and 15", g.serviced, g.sel);
      end
      step(8'h01, 1'b0, "single_again", g);
   endtask

   task automatic test_round_robin();
      obs_t g;
      int   prev;
      apply_reset();
      prev = -1;
      for (int i = 0; i < 16; i++) begin
         step(8'hFF, 1'b0, "rr_all", g);
         checks++;
         if (g.sel !== 4'(i % 8) || int'(g.sel) == prev) begin
            errors++;
            $display("FAIL rr_order: cycle %0d got sel=%0d (prev %0d), expected %0d", i, g.sel, prev, i % 8);
         end
         prev = int'(g.sel);
      end
   endtask

   task automatic test_starvation();
      obs_t g;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         step(8'h10, 1'b1, "starve_lsu", g);
         checks++;
         if (g.lsu_grant !== 1'b1) begin
            errors++;
            $display("FAIL starve_lsu: cycle %0d got lsu_grant=%b, expected 1", i, g.lsu_grant);
         end
      end
      step(8'h10, 1'b1, "starve_relief", g);
      checks++;
      if (g.serviced !== 8'h10 || g.stall !== 1'b1 || g.sel !== 4'd4 || g.lsu_grant !== 1'b0) begin
         errors++;
         $display("FAIL starve_relief: got serviced=%h stall=%b sel=%0d grant=%b, expected 10 1 4 0",
                  g.serviced, g.stall, g.sel, g.lsu_grant);
      end
      step(8'h10, 1'b1, "starve_lsu_again", g);
      checks++;
      if (g.lsu_grant !== 1'b1 || g.stall !== 1'b0) begin
         errors++;
         $display("FAIL starve_lsu_again: got grant=%b stall=%b, expected 1 0", g.lsu_grant, g.stall);
      end
   endtask

   task automatic test_wrap();
      obs_t g;
      apply_reset();
      step(8'h10, 1'b0, "wrap_setup", g);
      step(8'h21, 1'b0, "wrap_first", g);
      checks++;
      if (g.sel !== 4'd5) begin
         errors++;
         $display("FAIL wrap_first: got sel=%0d, expected 5", g.sel);
      end
      step(8'h21, 1'b0, "wrap_second", g);
      checks++;
      if (g.sel !== 4'd0) begin
         errors++;
         $display("FAIL wrap_second: got sel=%0d, expected 0", g.sel);
      end
   endtask

   task automatic test_all_request();
      obs_t g;
      apply_reset();
      step(8'hFF, 1'b0, "all_alu0", g);
      step(8'hFF, 1'b1, "all_lsu_a", g);
      step(8'hFF, 1'b1, "all_lsu_b", g);
      checks++;
      if (g.lsu_grant !== 1'b1 || g.sel !== 4'd8) begin
         errors++;
         $display("FAIL all_lsu: got grant=%b sel=%0d, expected 1 8", g.lsu_grant, g.sel);
      end
      step(8'hFF, 1'b0, "all_ptr_kept", g);
      checks++;
      if (g.sel !== 4'd1) begin
         errors++;
         $display("FAIL all_ptr_kept: got sel=%0d, expected 1", g.sel);
      end
   endtask

   task automatic test_async_reset();
      obs_t g;
      apply_reset();
      step(8'h00, 1'b0, "async_idle", g);
      step(8'h04, 1'b0, "async_pre", g);
      checks++;
      if (g.serviced !== 8'h04) begin
         errors++;
         $display("FAIL async_pre: got serviced=%h, expected 04", g.serviced);
      end
      valid = 8'h0C;
      rst   = 1'b1;
      model_reset();
      #1;
      checks++;
      if (observe() !== obs_t'({8'h00, 1'b0, 4'd15, 1'b0})) begin
         errors++;
         $display("FAIL async_reset: got %h, expected serviced=00 grant=0 sel=15 stall=0", observe());
      end
      @(negedge clk);
      rst = 1'b0;
      step(8'h0C, 1'b0, "async_restart", g);
      checks++;
      if (g.sel !== 4'd2) begin
         errors++;
         $display("FAIL async_restart: got sel=%0d, expected 2", g.sel);
      end
   endtask

   task automatic test_idle();
      obs_t g;
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         step(8'h00, 1'b0, "idle", g);
         checks++;
         if (g.sel !== 4'd15 || g.serviced !== 8'h00 || g.lsu_grant !== 1'b0 || g.stall !== 1'b0) begin
            errors++;
            $display("FAIL idle: cycle %0d got %h, expected idle outputs", i, g);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      valid   = '0;
      lsu_req = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_starvation();
      test_wrap();
      test_all_request();
      test_async_reset();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vgpr_wb_arbiter.md
VGPR_WB_ARBITER -- requirements
Module: vgpr_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port alu_queue_entry_valid, input, 8 bits: write-back request per ALU (bits 0-3 SIMD0-3, bits 4-7 SIMF0-3), driven by each unit's rfa_queue_entry_valid.
REQ-004 SHALL have port lsu_dest_wr_req, input, 1 bit: LSU register write-back request.
REQ-005 SHALL have port alu_queue_entry_serviced, output, 8 bits: one-hot grant pulse per ALU, wired to each unit's rfa_queue_entry_serviced.
REQ-006 SHALL have port lsu_wr_grant, output, 1 bit: LSU write-back granted this cycle.
REQ-007 SHALL have port wr_fu_select, output, 4 bits: encoded owner of the register-file write port (0-7 ALU index, 8 LSU, 15 none).
REQ-008 SHALL have port lsu_stall, output, 1 bit: LSU must hold off its write-back this cycle (starvation relief).

Function
REQ-009 SHALL register all outputs: a request sampled in cycle N produces its grant in cycle N+1.
REQ-010 SHALL grant at most one requester per cycle; alu_queue_entry_serviced is zero or one-hot, and it is never asserted together with lsu_wr_grant.
REQ-011 SHALL give lsu_dest_wr_req absolute priority over ALUs unless starvation relief is active (REQ-015).
REQ-012 SHALL arbitrate ALUs round-robin: search starts at rr_ptr and wraps 7->0; after a grant to index i, rr_ptr becomes (i+1) mod 8.
REQ-013 SHALL exclude any ALU granted in cycle N from arbitration in cycle N+1, because the requester still shows valid for one cycle after the serviced pulse.
REQ-014 SHALL keep a 4-bit starve_cnt: increment (saturating at 15) on each cycle where an eligible ALU request loses to the LSU; clear on any ALU grant or when no ALU is eligible.
REQ-015 SHALL, when starve_cnt reaches STARVE_LIMIT (8), give ALUs priority for one cycle: grant the round-robin ALU winner, assert lsu_stall in that same output cycle, clear starve_cnt.
REQ-016 SHALL drive wr_fu_select to 15, and serviced and lsu_wr_grant to 0, on any cycle with no grant.
REQ-017 SHALL, with no requests, leave rr_ptr and starve_cnt unchanged apart from the clear in REQ-014.
REQ-018 SHALL let the LSU win and leave rr_ptr unchanged when the LSU and all ALUs request simultaneously and starve_cnt < 8.

Reset
REQ-019 SHALL, while rst is high, force alu_queue_entry_serviced=0, lsu_wr_grant=0, lsu_stall=0, wr_fu_select=15, rr_ptr=0, starve_cnt=0, and clear the exclusion mask immediately, independent of clk.
REQ-020 SHALL drop any grant in flight when reset is asserted mid-operation; on the first edge after rst falls, arbitration restarts from rr_ptr=0.

Structure
REQ-021 SHALL take NUM_ALU=8, FU_LSU=4'd8, FU_NONE=4'd15 and STARVE_LIMIT=8 from the shared package.
REQ-022 SHALL put the rotating find-first search (8-bit request, 3-bit pointer in; one-hot grant, valid out) in one combinational sub-module, rr_find_first8.

Verification
REQ-023 SHALL have a test where, after reset, valid=8'h01 is held: serviced=8'h01 in the next cycle only, no grant the cycle after (exclusion), wr_fu_select=0 then 15.
REQ-024 SHALL have a test where valid=8'hFF is held for 16 cycles: grant order 0,1,...,7,0,... with no index repeated in consecutive cycles.
REQ-025 SHALL have a test where lsu_dest_wr_req and valid=8'h10 are held: lsu_wr_grant for 8 cycles, then serviced=8'h10 with lsu_stall=1 and wr_fu_select=4, then the LSU wins again.
REQ-026 SHALL have a test where rr_ptr=5 and valid=8'h21 (ALUs 0 and 5): ALU5 is granted first, then ALU0 (wrap) once ALU5 is excluded or idle.
REQ-027 SHALL have a test where rst is asserted asynchronously mid-stream while serviced=8'h04: outputs are zero and wr_fu_select=15 with no clock edge, and the first grant after release goes to the lowest requesting index.
REQ-028 SHALL have a test where all inputs are idle for 20 cycles: wr_fu_select stays 15 and no grant or stall ever asserts.
